// File: rtl/anna_vee_timer.sv
// Two-digit BCD seconds timer (00-99) with up/down counting, start/stop, clear and load-99,
// driving one multiplexed 7-segment digit pair and the raw BCD count.
module anna_vee_timer #(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned MUX_BITS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TickMax = PW'(TICK_CYCLES - 1);

    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic [2:0]          prev_q, prev_d;
    logic                run_q, run_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0]          ones_q, ones_d;
    logic [3:0]          tens_q, tens_d;
    logic [MUX_BITS-1:0] mux_q, mux_d;

    logic start_ev, clear_ev, load_ev, dir_down, tick, sel;
    logic [3:0] digit;

    logic unused_pins;
    assign unused_pins = ^{uio_in, ui_in[7:4]};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Edge detect on the synchronized level; prev_q holds {load, clear, start}.
    always_comb begin
        start_ev = sync2_q[0] & ~prev_q[0];
        clear_ev = sync2_q[1] & ~prev_q[1];
        load_ev  = sync2_q[3] & ~prev_q[2];
        dir_down = sync2_q[2];
        tick     = run_q && (presc_q == TickMax);
    end

    always_comb begin
        sync1_d = ui_in[3:0];
        sync2_d = sync1_q;
        prev_d  = {sync2_q[3], sync2_q[1], sync2_q[0]};
        mux_d   = mux_q + MUX_BITS'(1);
        run_d   = run_q;
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;

        if (clear_ev) begin
            run_d   = 1'b0;
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
        end else begin
            run_d = run_q ^ start_ev;
            if (load_ev) begin
                presc_d = '0;
                ones_d  = 4'd9;
                tens_d  = 4'd9;
            end else if (run_q) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (!dir_down) begin
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                        // Reaching or sitting at 00 while counting down ends the run.
                        ones_d = 4'd0;
                        run_d  = 1'b0;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            run_q   <= 1'b0;
            presc_q <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            mux_q   <= '0;
        end else if (ena) begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            presc_q <= presc_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            mux_q   <= mux_d;
        end
    end

    always_comb begin
        sel     = mux_q[MUX_BITS-1];
        digit   = sel ? tens_q : ones_q;
        uo_out  = {sel, seg7(digit)};
        uio_out = {tens_q, ones_q};
        uio_oe  = 8'hFF;
    end

endmodule

// File: tb/tb_anna_vee_timer.sv
// Randomized and directed bench for anna_vee_timer against an integer-count reference model.
module tb_anna_vee_timer;

    localparam int unsigned T  = 4;
    localparam int unsigned MB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count as an integer 0..99, pin history of the last three enabled edges.
    int         m_cnt, m_presc, m_mux;
    bit         m_run;
    logic [3:0] h1, h2, h3;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    anna_vee_timer #(.TICK_CYCLES(T), .MUX_BITS(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_presc = 0; m_mux = 0; m_run = 0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    task automatic model_step(input logic [3:0] pin);
        bit st, cl, ld, dn, tk, nrun;
        st = h2[0] & ~h3[0];
        cl = h2[1] & ~h3[1];
        ld = h2[3] & ~h3[3];
        dn = h2[2];
        tk = m_run && (m_presc == T - 1);
        h3 = h2; h2 = h1; h1 = pin;
        m_mux = (m_mux + 1) % (1 << MB);
        if (cl) begin
            m_cnt = 0; m_presc = 0; m_run = 0;
        end else begin
            nrun = m_run ^ st;
            if (ld) begin
                m_cnt = 99; m_presc = 0;
            end else if (m_run) begin
                m_presc = tk ? 0 : m_presc + 1;
                if (tk) begin
                    if (!dn) m_cnt = (m_cnt + 1) % 100;
                    else begin
                        if (m_cnt > 0) m_cnt = m_cnt - 1;
                        if (m_cnt == 0) nrun = 0;
                    end
                end
            end
            m_run = nrun;
        end
    endtask

    function automatic logic [7:0] exp_uio();
        return {4'(m_cnt / 10), 4'(m_cnt % 10)};
    endfunction

    function automatic logic [7:0] exp_uo();
        int sel;
        sel = (m_mux >> (MB - 1)) & 1;
        return {sel[0], seg_tab[sel ? m_cnt / 10 : m_cnt % 10]};
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, "/uo_out"}, uo_out, exp_uo());
        check_eq({tag, "/uio_out"}, uio_out, exp_uio());
        check_eq({tag, "/uio_oe"}, uio_oe, 8'hFF);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else if (ena) model_step(ui_in[3:0]);
        #1;
        compare_all("cyc");
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input int b);
        ui_in[b] = 1'b1;
        step();
        ui_in[b] = 1'b0;
    endtask

    // Asserted between edges so the asynchronous path is observed before any clock.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst/uo_out", uo_out, 8'h3F);
        check_eq("rst/uio_out", uio_out, 8'h00);
        check_eq("rst/uio_oe", uio_oe, 8'hFF);
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; ui_in = '0; uio_in = '0;
        model_reset();
        #2;
        async_reset();

        // Idle: sel toggles, count holds.
        cyc(8);
        check_eq("idle/count", uio_out, 8'h00);

        // Up count with carry into tens.
        pulse(0);
        cyc(45);
        check_eq("up/carry", uio_out, 8'h10);

        // Up wrap from 99.
        pulse(1); cyc(4);
        pulse(3); cyc(4);
        check_eq("load/99", uio_out, 8'h99);
        pulse(0); cyc(6);
        check_eq("up/wrap", uio_out, 8'h00);
        cyc(4);
        check_eq("up/after_wrap", uio_out, 8'h01);

        // Down with borrow, then stop at 00.
        pulse(1); cyc(4);
        ui_in[2] = 1'b1; cyc(3);
        pulse(3); cyc(3);
        pulse(0); cyc(42);
        check_eq("down/borrow", uio_out, 8'h89);
        cyc(4 * 89 + 20);
        check_eq("down/stop00", uio_out, 8'h00);

        // Clear while running at 37.
        ui_in[2] = 1'b0;
        pulse(1); cyc(3);
        pulse(0);
        for (int i = 0; i < 400 && m_cnt != 37; i++) step();
        check_eq("clr/reach37", uio_out, 8'h37);
        pulse(1); cyc(3);
        check_eq("clr/zero", uio_out, 8'h00);
        cyc(10);
        check_eq("clr/stopped", uio_out, 8'h00);
        ui_in = 8'h03; step(); ui_in = 8'h00;
        cyc(20);
        check_eq("clr_start/idle", uio_out, 8'h00);

        // ena freeze, then mid-count reset.
        pulse(0); cyc(20);
        ena = 1'b0; cyc(20);
        ena = 1'b1; cyc(20);
        async_reset();
        cyc(5);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            ena      = ($urandom_range(0, 15) != 0);
            ui_in[0] = ($urandom_range(0, 39) == 0);
            ui_in[1] = ($urandom_range(0, 299) == 0);
            ui_in[3] = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) ui_in[2] = ~ui_in[2];
            ui_in[7:4] = 4'($urandom);
            uio_in     = 8'($urandom);
            if ($urandom_range(0, 999) == 0) async_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
